wshb_sdram_arbiter: RTL and testbench

- Shares the single SDRAM Wishbone slave port (wshb_if_sdram side of hw_support, 32-bit data) between two Wishbone masters.
- m0 is the VGA framebuffer reader; m1 is the pattern/frame writer.
- Runs in the sys_clk (100 MHz) domain. It grants the bus for whole Wishbone cycles (cyc-framed), using round-robin arbitration on contention.

---
 rtl/wshb_sdram_arbiter_if.sv | 29 ++
 rtl/wshb_sdram_arbiter.sv | 128 ++++++++++++
 tb/tb_wshb_sdram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_sdram_arbiter_if.sv
// Wishbone bus bundle shared by both masters and the SDRAM slave port.
// The master modport drives requests; the slave modport drives responses.
interface wshb_sdram_arbiter_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADR_W      = 32
);
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [ADR_W-1:0]        adr;
   logic [8*DATA_BYTES-1:0] dat_ms;
   logic [DATA_BYTES-1:0]   sel;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic                    ack;
   logic                    err;
   logic                    rty;
   logic [8*DATA_BYTES-1:0] dat_sm;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  ack, err, rty, dat_sm
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output ack, err, rty, dat_sm
   );
endinterface

// File: rtl/wshb_sdram_arbiter.sv
// Two-master Wishbone arbiter for the SDRAM slave port: whole cyc-framed
// grants, round-robin on contention, direct handoff between owners.
module wshb_sdram_arbiter #(
   parameter int DATA_BYTES = 4,
   parameter int ADR_W      = 32
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   wshb_sdram_arbiter_if.slave    m0,
   wshb_sdram_arbiter_if.slave    m1,
   wshb_sdram_arbiter_if.master   s,
   output logic [1:0]             gnt
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t                  state;
   logic                    last_owner;
   logic [ADR_W-1:0]        adr_mux;
   logic [8*DATA_BYTES-1:0] wdat_mux;
   logic [8*DATA_BYTES-1:0] rdat;
   logic [DATA_BYTES-1:0]   sel_mux;

   // Grant is held for as long as the owner keeps cyc high; no preemption.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         gnt        <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (m0.cyc && (!m1.cyc || last_owner)) begin
                  state      <= OWN0;
                  last_owner <= 1'b0;
                  gnt        <= 2'b01;
               end else if (m1.cyc) begin
                  state      <= OWN1;
                  last_owner <= 1'b1;
                  gnt        <= 2'b10;
               end
            end
            OWN0: begin
               if (!m0.cyc) begin
                  if (m1.cyc) begin
                     state      <= OWN1;
                     last_owner <= 1'b1;
                     gnt        <= 2'b10;
                  end else begin
                     state <= IDLE;
                     gnt   <= 2'b00;
                  end
               end
            end
            OWN1: begin
               if (!m1.cyc) begin
                  if (m0.cyc) begin
                     state      <= OWN0;
                     last_owner <= 1'b0;
                     gnt        <= 2'b01;
                  end else begin
                     state <= IDLE;
                     gnt   <= 2'b00;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 2'b00;
            end
         endcase
      end
   end

   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      adr_mux  = '0;
      wdat_mux = '0;
      sel_mux  = '0;
      s.cti    = '0;
      s.bte    = '0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.rty   = 1'b0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.rty   = 1'b0;
      case (state)
         OWN0: begin
            s.cyc    = m0.cyc;
            s.stb    = m0.stb;
            s.we     = m0.we;
            adr_mux  = m0.adr;
            wdat_mux = m0.dat_ms;
            sel_mux  = m0.sel;
            s.cti    = m0.cti;
            s.bte    = m0.bte;
            m0.ack   = s.ack;
            m0.err   = s.err;
            m0.rty   = s.rty;
         end
         OWN1: begin
            s.cyc    = m1.cyc;
            s.stb    = m1.stb;
            s.we     = m1.we;
            adr_mux  = m1.adr;
            wdat_mux = m1.dat_ms;
            sel_mux  = m1.sel;
            s.cti    = m1.cti;
            s.bte    = m1.bte;
            m1.ack   = s.ack;
            m1.err   = s.err;
            m1.rty   = s.rty;
         end
         default: ;
      endcase
   end

   assign s.adr    = adr_mux;
   assign s.dat_ms = wdat_mux;
   assign s.sel    = sel_mux;
   assign rdat     = s.dat_sm;
   assign m0.dat_sm = rdat;
   assign m1.dat_sm = rdat;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Directed bench for wshb_sdram_arbiter: a scoreboard of expected slave
// responses and grant sequence, checked with immediate assertions.
module tb_wshb_sdram_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] gnt;

   int unsigned tests = 0;
   int unsigned fails = 0;

   wshb_sdram_arbiter_if #(.DATA_BYTES(4), .ADR_W(32)) m0_bus ();
   wshb_sdram_arbiter_if #(.DATA_BYTES(4), .ADR_W(32)) m1_bus ();
   wshb_sdram_arbiter_if #(.DATA_BYTES(4), .ADR_W(32)) s_bus ();

   wshb_sdram_arbiter #(.DATA_BYTES(4), .ADR_W(32)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .m0      (m0_bus),
      .m1      (m1_bus),
      .s       (s_bus),
      .gnt     (gnt)
   );

   typedef struct {
      int unsigned who;
      logic        is_err;
      logic [31:0] data;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] gnt_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic observe();
      logic a0, a1;
      exp_t e;
      a0 = m0_bus.ack | m0_bus.err | m0_bus.rty;
      a1 = m1_bus.ack | m1_bus.err | m1_bus.rty;
      if (a0 | a1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 64'({a1, a0}), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_owner", 64'({a1, a0}), (e.who == 0) ? 64'd1 : 64'd2);
            if (e.who == 0) begin
               chk("sb_err0", 64'(m0_bus.err), 64'(e.is_err));
               if (!e.is_err) chk("sb_data0", 64'(m0_bus.dat_sm), 64'(e.data));
            end else begin
               chk("sb_err1", 64'(m1_bus.err), 64'(e.is_err));
               if (!e.is_err) chk("sb_data1", 64'(m1_bus.dat_sm), 64'(e.data));
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      observe();
   endtask

   task automatic slave_ack(input int unsigned who, input logic [31:0] d);
      s_bus.ack    = 1'b1;
      s_bus.dat_sm = d;
      sb.push_back('{who, 1'b0, d});
   endtask

   task automatic quiet_all();
      m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
      m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
      m0_bus.cti = 3'b000; m1_bus.cti = 3'b000;
      s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.rty = 1'b0;
   endtask

   task automatic set_m(input int unsigned who, input logic cyc, input logic [31:0] adr);
      if (who == 0) begin
         m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.adr = adr;
      end else begin
         m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.adr = adr;
      end
   endtask

   initial begin
      logic [1:0]  prev;
      logic [1:0]  exp_g;
      logic [31:0] dcount;
      int unsigned owner;
      bit          got;

      rst = 1'b1;
      m0_bus.adr = '0; m0_bus.dat_ms = '0; m0_bus.sel = 4'hF; m0_bus.bte = 2'b00;
      m1_bus.adr = '0; m1_bus.dat_ms = '0; m1_bus.sel = 4'hF; m1_bus.bte = 2'b00;
      s_bus.dat_sm = '0;
      quiet_all();
      dcount = 32'hA000_0000;

      // Reset state
      mid();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_s_cyc", 64'(s_bus.cyc), 64'd0);
      chk("rst_s_adr", 64'(s_bus.adr), 64'd0);
      step();
      rst = 1'b0;

      // Single m0 read
      step();
      m0_bus.we = 1'b0;
      set_m(0, 1'b1, 32'h100);
      mid();
      chk("rd_gnt_latency", 64'(gnt), 64'd0);
      chk("rd_s_cyc_latency", 64'(s_bus.cyc), 64'd0);
      step();
      mid();
      chk("rd_gnt", 64'(gnt), 64'd1);
      chk("rd_s_adr", 64'(s_bus.adr), 64'h100);
      chk("rd_s_cyc", 64'(s_bus.cyc), 64'd1);
      step();
      slave_ack(0, 32'hDEAD_BEEF);
      mid();
      chk("rd_m0_ack", 64'(m0_bus.ack), 64'd1);
      chk("rd_m1_ack", 64'(m1_bus.ack), 64'd0);
      step();
      quiet_all();
      mid();
      step();
      mid();
      chk("rd_release_gnt", 64'(gnt), 64'd0);

      // Simultaneous request after reset: strict alternation, no idle gap
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      set_m(0, 1'b1, 32'h1000);
      set_m(1, 1'b1, 32'h2000);
      gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
      gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
      prev = 2'b00;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         for (int c = 0; c < 8 && !got; c++) begin
            mid();
            if (gnt !== prev) got = 1'b1;
            else step();
         end
         exp_g = gnt_q.pop_front();
         chk("rr_gnt", 64'(gnt), 64'(exp_g));
         prev  = gnt;
         owner = (exp_g == 2'b01) ? 0 : 1;
         for (int b = 0; b < 3; b++) begin
            step();
            dcount = dcount + 1;
            slave_ack(owner, dcount);
            mid();
         end
         step();
         s_bus.ack = 1'b0;
         set_m(owner, 1'b0, 32'h0);
         mid();
         step();
         if (g < 2) set_m(owner, 1'b1, (owner == 0) ? 32'h1000 : 32'h2000);
      end
      mid();
      chk("rr_final_idle", 64'(gnt), 64'd0);

      // Burst atomicity: m1 holds 8 beats despite m0 requesting at beat 2
      step();
      m1_bus.cti = 3'b010;
      set_m(1, 1'b1, 32'h200);
      mid();
      step();
      mid();
      chk("bu_gnt_start", 64'(gnt), 64'd2);
      for (int b = 0; b < 8; b++) begin
         step();
         m1_bus.cti = (b == 7) ? 3'b111 : 3'b010;
         m1_bus.adr = 32'h200 + 32'(4 * b);
         if (b == 2) set_m(0, 1'b1, 32'h300);
         dcount = dcount + 1;
         slave_ack(1, dcount);
         mid();
         chk("bu_gnt_hold", 64'(gnt), 64'd2);
         chk("bu_s_cti", 64'(s_bus.cti), (b == 7) ? 64'd7 : 64'd2);
      end
      step();
      s_bus.ack = 1'b0;
      m1_bus.cti = 3'b000;
      set_m(1, 1'b0, 32'h0);
      mid();
      chk("bu_gnt_after_drop", 64'(gnt), 64'd2);
      step();
      mid();
      chk("bu_handoff_m0", 64'(gnt), 64'd1);
      chk("bu_s_adr_m0", 64'(s_bus.adr), 64'h300);

      // Async reset mid-cycle while m0 owns with stb=1
      step();
      dcount = dcount + 1;
      slave_ack(0, dcount);
      mid();
      #2;
      rst = 1'b1;
      #1;
      chk("ar_s_cyc", 64'(s_bus.cyc), 64'd0);
      chk("ar_s_stb", 64'(s_bus.stb), 64'd0);
      chk("ar_m0_ack", 64'(m0_bus.ack), 64'd0);
      chk("ar_gnt", 64'(gnt), 64'd0);
      step();
      rst = 1'b0;
      s_bus.ack = 1'b0;
      set_m(1, 1'b1, 32'h2000);
      mid();
      chk("ar_gnt_post", 64'(gnt), 64'd0);
      step();
      mid();
      chk("ar_tie_m0", 64'(gnt), 64'd1);
      step();
      quiet_all();
      mid();
      step();
      mid();
      chk("ar_idle", 64'(gnt), 64'd0);

      // Idle response filtering
      step();
      s_bus.ack = 1'b1;
      s_bus.err = 1'b1;
      for (int c = 0; c < 2; c++) begin
         mid();
         chk("if_resp", 64'({m1_bus.ack, m1_bus.err, m1_bus.rty, m0_bus.ack, m0_bus.err, m0_bus.rty}), 64'd0);
         chk("if_gnt", 64'(gnt), 64'd0);
         step();
      end
      s_bus.ack = 1'b0;
      s_bus.err = 1'b0;

      // Write path and error routing
      m1_bus.we     = 1'b1;
      m1_bus.dat_ms = 32'h1234_5678;
      m1_bus.sel    = 4'hF;
      set_m(1, 1'b1, 32'h40);
      mid();
      step();
      mid();
      chk("wr_gnt", 64'(gnt), 64'd2);
      chk("wr_s_we", 64'(s_bus.we), 64'd1);
      chk("wr_s_dat", 64'(s_bus.dat_ms), 64'h1234_5678);
      chk("wr_s_adr", 64'(s_bus.adr), 64'h40);
      chk("wr_s_sel", 64'(s_bus.sel), 64'hF);
      step();
      s_bus.err = 1'b1;
      sb.push_back('{1, 1'b1, 32'h0});
      mid();
      chk("wr_m1_err", 64'(m1_bus.err), 64'd1);
      chk("wr_m0_err", 64'(m0_bus.err), 64'd0);
      step();
      quiet_all();
      mid();
      chk("wr_m1_err_1cyc", 64'(m1_bus.err), 64'd0);
      step();
      mid();
      chk("wr_idle", 64'(gnt), 64'd0);

      chk("sb_pending", 64'(sb.size()), 64'd0);
      chk("gnt_q_pending", 64'(gnt_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
